// File: rtl/stack_pkg.sv
`timescale 1ns/1ps
// stack_pkg
//   Shared definitions for the parametrised LIFO stack: default geometry and
//   the operation encoding produced by decoding {push, pop} under enable.
package stack_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stack_op_t;

    // A disabled cycle is indistinguishable from an idle one.
    function automatic stack_op_t decode_op(input logic en, input logic push, input logic pop);
        if (!en) return OP_NONE;
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_REPL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/param_stack_if.sv
`timescale 1ns/1ps
// param_stack_if
//   Request/status bundle between a stack user (master) and param_stack (slave).
//   Requests : enable, push, pop, data_in, clr_err
//   Responses: data_out, pop_valid, top, empty, full, overflow, underflow,
//              stackPointer (entry count, SP_W bits)
interface param_stack_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic              enable;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              pop_valid;
    logic [DATA_W-1:0] top;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic [SP_W-1:0]   stackPointer;

    modport master (
        output enable, push, pop, data_in, clr_err,
        input  data_out, pop_valid, top, empty, full, overflow, underflow, stackPointer
    );

    modport slave (
        input  enable, push, pop, data_in, clr_err,
        output data_out, pop_valid, top, empty, full, overflow, underflow, stackPointer
    );

endinterface

// File: rtl/stack_ram.sv
`timescale 1ns/1ps
// stack_ram
//   DATA_W x DEPTH storage for the stack: one synchronous write port and one
//   asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module stack_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset would turn it into flops and the
    // stack pointer already marks every entry as invalid after reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
`timescale 1ns/1ps
// param_stack
//   Parametrised LIFO (return-address / operand stack) growing upward, with
//   full/empty status, combinational peek, registered pop output with a valid
//   pulse, push+pop replace/bypass and sticky overflow/underflow flags.
//   clk : clock, all state changes on posedge
//   rst : asynchronous active-low reset
//   bus : param_stack_if slave modport (requests in, data/status out)
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input logic          clk,
    input logic          rst,
    param_stack_if.slave bus
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = $clog2(DEPTH);

    logic [SP_W-1:0]   sp;
    logic [DATA_W-1:0] data_out_q;
    logic              pop_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    stack_op_t         op;
    logic              empty;
    logic              full;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [AW-1:0]     top_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign op       = decode_op(bus.enable, bus.push, bus.pop);
    assign empty    = (sp == '0);
    assign full     = (sp == SP_W'(DEPTH));
    // Wraps when empty; the read result is masked off in that case.
    assign top_addr = AW'(sp - SP_W'(1));

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = AW'(sp);
        case (op)
            OP_PUSH: ram_we = !full;
            OP_REPL: begin
                // Replace overwrites the current top; on an empty stack the
                // value bypasses storage entirely.
                if (!empty) begin
                    ram_we    = 1'b1;
                    ram_waddr = top_addr;
                end
            end
            default: ;
        endcase
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.data_in),
        .raddr (top_addr),
        .rdata (ram_rdata)
    );

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; a later assignment in the same block wins, which is how
    // an error event overrides clr_err in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp          <= '0;
            data_out_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            if (bus.enable && bus.clr_err) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            case (op)
                OP_PUSH: begin
                    if (full) overflow_q <= 1'b1;
                    else      sp         <= sp + SP_W'(1);
                end
                OP_POP: begin
                    if (empty) begin
                        underflow_q <= 1'b1;
                    end else begin
                        data_out_q  <= ram_rdata;
                        sp          <= sp - SP_W'(1);
                        pop_valid_q <= 1'b1;
                    end
                end
                OP_REPL: begin
                    // Read of the old top happens before the write lands.
                    data_out_q  <= empty ? bus.data_in : ram_rdata;
                    pop_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.pop_valid    = pop_valid_q;
    assign bus.top          = empty ? '0 : ram_rdata;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.stackPointer = sp;

endmodule
